uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single 8-bit UART transmitter (din / wr_en / tx_busy byte interface) between NUM_REQ byte sources. It sits between the requesters (CPU console path, debug/trace producers) and the transmitter. It sequences one byte at a time through the transmitter's write handshake and can lock the transmitter to one requester for a multi-byte line, so lines do not interleave. It also detects a transmitter that never reports busy.

---
 rtl/uart_tx_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that shares one 8-bit UART transmitter between NUM_REQ byte
// sources. It issues one byte at a time through the transmitter's write handshake.
// A byte with last=0 locks the transmitter to its requester until that requester
// sends a byte with last=1, so lines from different sources never interleave.
// A transmitter that never raises busy after a write is reported as a timeout.
//
// Ports:
//   clk_in        system clock, rising edge
//   rst           asynchronous active-high reset
//   req_valid     per-requester byte available
//   req_data      per-requester byte, requester i at [8i+7:8i]
//   req_last      per-requester end-of-line flag
//   req_ready     one-hot accept strobe (valid & ready)
//   uart_din      registered byte to the transmitter
//   uart_wr_en    registered one-cycle write strobe
//   uart_tx_busy  transmitter busy
//   grant         one-hot current owner, 0 when idle and unlocked
//   locked        an owner holds the transmitter mid-line
//   timeout_err   sticky busy-timeout flag
//   err_clr       clears timeout_err (a new timeout in the same cycle wins)
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BUSY_TIMEOUT = 1023
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           uart_din,
  output logic                 uart_wr_en,
  input  logic                 uart_tx_busy,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 locked,
  output logic                 timeout_err,
  input  logic                 err_clr
);

  localparam int unsigned CntW = $clog2(BUSY_TIMEOUT + 1);
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    StIdle,
    StWaitBusy,
    StWaitDone
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic            locked_q, locked_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      din_q, din_d;
  logic            wr_en_q, wr_en_d;
  logic            err_q, err_d;

  logic [IdxW-1:0] cand;
  logic            cand_vld;
  logic [IdxW-1:0] cand_nxt;
  logic [7:0]      cand_data;
  logic            accept;
  logic            timeout_set;

  // Candidate selection. When locked only the owner may send; otherwise search
  // ptr, ptr+1, ... modulo NUM_REQ. The loop runs from the farthest offset down so
  // the nearest valid requester to ptr is the last assignment and wins.
  always_comb begin
    logic [IdxW:0]   sum;
    logic [IdxW-1:0] idx;
    cand     = '0;
    cand_vld = 1'b0;
    sum      = '0;
    idx      = '0;
    if (locked_q) begin
      cand     = owner_q;
      cand_vld = req_valid[owner_q];
    end else begin
      for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
        sum = {1'b0, ptr_q} + (IdxW + 1)'(k);
        if (sum >= (IdxW + 1)'(NUM_REQ)) begin
          sum = sum - (IdxW + 1)'(NUM_REQ);
        end
        idx = sum[IdxW-1:0];
        if (req_valid[idx]) begin
          cand     = idx;
          cand_vld = 1'b1;
        end
      end
    end
  end

  // Byte mux and the pointer value that follows the candidate.
  always_comb begin
    logic [IdxW:0] nxt;
    cand_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (cand == IdxW'(i)) begin
        cand_data = req_data[8*i +: 8];
      end
    end
    nxt = {1'b0, cand} + 1'b1;
    if (nxt == (IdxW + 1)'(NUM_REQ)) begin
      nxt = '0;
    end
    cand_nxt = nxt[IdxW-1:0];
  end

  // Never write into a busy transmitter; it has no reset and may still be
  // shifting out a byte when our reset is released.
  assign accept = (state_q == StIdle) && cand_vld && !uart_tx_busy && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[cand] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    locked_d    = locked_q;
    cnt_d       = cnt_q;
    din_d       = din_q;
    wr_en_d     = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          din_d   = cand_data;
          wr_en_d = 1'b1;
          owner_d = cand;
          cnt_d   = '0;
          state_d = StWaitBusy;
          if (req_last[cand]) begin
            locked_d = 1'b0;
            ptr_d    = cand_nxt;
          end else begin
            locked_d = 1'b1;
          end
        end
      end
      StWaitBusy: begin
        if (uart_tx_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == CntW'(BUSY_TIMEOUT)) begin
          // Byte is dropped; the lock stays so the line owner can continue.
          timeout_set = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!uart_tx_busy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (timeout_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      owner_q  <= '0;
      locked_q <= 1'b0;
      cnt_q    <= '0;
      din_q    <= 8'h00;
      wr_en_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
      cnt_q    <= cnt_d;
      din_q    <= din_d;
      wr_en_q  <= wr_en_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    grant = '0;
    if ((state_q != StIdle) || locked_q) begin
      grant[owner_q] = 1'b1;
    end
  end

  assign uart_din    = din_q;
  assign uart_wr_en  = wr_en_q;
  assign locked      = locked_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the arbitration rules and a
// simple transmitter model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 15;

  logic           clk_in = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     uart_din;
  logic           uart_wr_en;
  logic           uart_tx_busy;
  logic [N-1:0]   grant;
  logic           locked;
  logic           timeout_err;
  logic           err_clr;

  always #5 clk_in = ~clk_in;

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .BUSY_TIMEOUT (TO)
  ) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .uart_din     (uart_din),
    .uart_wr_en   (uart_wr_en),
    .uart_tx_busy (uart_tx_busy),
    .grant        (grant),
    .locked       (locked),
    .timeout_err  (timeout_err),
    .err_clr      (err_clr)
  );

  int checks = 0;
  int errors = 0;

  // Pending bytes per requester: {last, data}.
  logic [8:0] rq [N][$];
  // Reference model state.
  int         m_ptr, m_owner;
  bit         m_lock;
  bit         prev_acc;
  logic [7:0] din_q [$];
  int         order_q [$];
  // Transmitter model.
  int         tx_rem;
  bit         tx_alive;
  int         busy_min, busy_max;
  // Snapshots taken on the falling edge.
  logic [N-1:0] s_ready, s_grant;
  logic [7:0]   s_din;
  logic         s_wr_en, s_err, s_busy, s_locked;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = rq[i][0][7:0];
        req_last[i]        = rq[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // Who the rules say should be served next, or -1 if nobody.
  function automatic int m_pick();
    if (m_lock) return (rq[m_owner].size() > 0) ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      if (rq[(m_ptr + k) % N].size() > 0) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr    = 0;
    m_owner  = 0;
    m_lock   = 1'b0;
    prev_acc = 1'b0;
    din_q.delete();
  endtask

  // One clock: sample and check on the falling edge, then update the
  // transmitter model and requester drives just after the rising edge.
  task automatic cycle();
    int idx;
    int exp;
    @(negedge clk_in);
    s_ready  = req_ready;
    s_grant  = grant;
    s_din    = uart_din;
    s_wr_en  = uart_wr_en;
    s_err    = timeout_err;
    s_busy   = uart_tx_busy;
    s_locked = locked;
    chk("ready_onehot", 32'($onehot0(req_ready)), 1);
    chk("wr_en_timing", uart_wr_en, prev_acc);
    chk("wr_while_busy", uart_wr_en & uart_tx_busy, 0);
    chk("locked", locked, m_lock);
    if (uart_wr_en) begin
      chk("din_pending", din_q.size() > 0, 1);
      if (din_q.size() > 0) chk("din", uart_din, din_q.pop_front());
    end
    prev_acc = 1'b0;
    if (req_ready != '0) begin
      idx = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
      exp = m_pick();
      chk("acc_busy", uart_tx_busy, 0);
      chk("acc_idx", idx, exp);
      if (exp >= 0) begin
        din_q.push_back(rq[exp][0][7:0]);
        m_owner = exp;
        if (rq[exp][0][8]) begin
          m_lock = 1'b0;
          m_ptr  = (exp + 1) % N;
        end else begin
          m_lock = 1'b1;
        end
        void'(rq[exp].pop_front());
      end
      order_q.push_back(idx);
      prev_acc = 1'b1;
    end
    @(posedge clk_in);
    if (s_wr_en && tx_alive) tx_rem = $urandom_range(busy_max, busy_min);
    else if (tx_rem > 0) tx_rem--;
    #1;
    uart_tx_busy = (tx_rem > 0);
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    bit pend;
    n = 0;
    pend = 1'b1;
    while (pend && n < limit) begin
      pend = (tx_rem > 0) || (din_q.size() > 0) || prev_acc;
      for (int i = 0; i < N; i++) if (rq[i].size() > 0) pend = 1'b1;
      if (pend) begin
        cycle();
        n++;
      end
    end
    chk("drain_bound", n < limit, 1);
    cycle();
    cycle();
  endtask

  task automatic wait_wr(input string tag);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!s_wr_en && n < 40);
    chk(tag, s_wr_en, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit last_busy;
    int exp_fair[5];
    int exp_lock[4];
    int exp_wrap[3];
    exp_fair = '{0, 1, 2, 3, 0};
    exp_lock = '{2, 2, 2, 0};
    exp_wrap = '{3, 1, 3};

    rst = 1'b1; req_valid = '1; req_data = '0; req_last = '1;
    uart_tx_busy = 1'b0; err_clr = 1'b0;
    tx_rem = 0; tx_alive = 1'b1; busy_min = 1; busy_max = 5;
    model_reset();
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_din", uart_din, 0);
    chk("rst_wr_en", uart_wr_en, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_locked", locked, 0);
    chk("rst_ready", req_ready, 0);
    drive();
    do_reset();

    // Single byte from requester 1.
    busy_min = 3; busy_max = 3;
    rq[1].push_back({1'b1, 8'h55});
    drive();
    n = 0;
    do begin cycle(); n++; end while (s_ready == '0 && n < 10);
    chk("single_ready", s_ready, 4'b0010);
    cycle();
    chk("single_wr", s_wr_en, 1);
    chk("single_din", s_din, 8'h55);
    chk("single_grant_wr", s_grant, 4'b0010);
    n = 0;
    while (!s_busy && n < 10) begin cycle(); n++; end
    chk("single_grant_busy", s_grant, 4'b0010);
    while (s_busy && n < 20) begin cycle(); n++; end
    chk("single_grant_fall", s_grant, 4'b0010);
    cycle();
    chk("single_grant_idle", s_grant, 0);
    chk("single_unlocked", s_locked, 0);
    busy_min = 1; busy_max = 5;

    // Fairness: everyone valid after reset.
    do_reset();
    order_q.delete();
    for (int i = 0; i < N; i++) begin
      rq[i].push_back({1'b1, 8'($urandom)});
      rq[i].push_back({1'b1, 8'($urandom)});
    end
    drive();
    drain(300);
    chk("fair_count", order_q.size(), 8);
    if (order_q.size() >= 5) for (int i = 0; i < 5; i++) chk("fair_order", order_q[i], exp_fair[i]);

    // Line lock: requester 2 holds the transmitter while requester 0 waits.
    do_reset();
    order_q.delete();
    rq[2].push_back({1'b0, 8'h41});
    rq[2].push_back({1'b0, 8'h42});
    rq[2].push_back({1'b1, 8'h0A});
    drive();
    n = 0;
    do begin cycle(); n++; end while (s_ready == '0 && n < 10);
    rq[0].push_back({1'b1, 8'h77});
    drive();
    drain(300);
    chk("lock_count", order_q.size(), 4);
    if (order_q.size() >= 4) for (int i = 0; i < 4; i++) chk("lock_order", order_q[i], exp_lock[i]);

    // Pointer wrap: after requester 3, the search starts again at 0.
    do_reset();
    order_q.delete();
    rq[3].push_back({1'b1, 8'h33});
    drive();
    drain(100);
    rq[1].push_back({1'b1, 8'h11});
    rq[3].push_back({1'b1, 8'h34});
    drive();
    drain(100);
    chk("wrap_count", order_q.size(), 3);
    if (order_q.size() >= 3) for (int i = 0; i < 3; i++) chk("wrap_order", order_q[i], exp_wrap[i]);

    // Busy timeout with a transmitter that never reports busy.
    do_reset();
    tx_alive = 1'b0;
    rq[0].push_back({1'b1, 8'hA0});
    drive();
    wait_wr("to1_wr");
    n = 0;
    do begin cycle(); n++; end while (!s_err && n < 40);
    chk("to_latency", n, 16);
    chk("to_grant_idle", s_grant, 0);
    err_clr = 1'b1; cycle(); err_clr = 1'b0; cycle();
    chk("clr_alone", s_err, 0);
    rq[0].push_back({1'b0, 8'hA1});
    drive();
    wait_wr("to2_wr");
    repeat (14) cycle();
    err_clr = 1'b1; cycle(); err_clr = 1'b0; cycle();
    chk("set_wins", s_err, 1);
    chk("to_lock_kept", s_locked, 1);
    chk("to_grant_locked", s_grant, 4'b0001);
    err_clr = 1'b1; cycle(); err_clr = 1'b0; cycle();
    chk("clr_err", s_err, 0);
    chk("clr_keeps_lock", s_locked, 1);
    tx_alive = 1'b1;
    rq[0].push_back({1'b1, 8'hA2});
    drive();
    drain(100);
    chk("to_released", s_locked, 0);

    // Reset while the transmitter is mid-byte.
    do_reset();
    busy_min = 12; busy_max = 12;
    rq[0].push_back({1'b0, 8'hC3});
    drive();
    wait_wr("mid_wr");
    repeat (3) cycle();
    chk("mid_busy", s_busy, 1);
    rq[1].push_back({1'b1, 8'hD4});
    drive();
    rst = 1'b1;
    #1;
    chk("mid_grant", grant, 0);
    chk("mid_locked", locked, 0);
    chk("mid_wr_en", uart_wr_en, 0);
    chk("mid_din", uart_din, 0);
    chk("mid_err", timeout_err, 0);
    chk("mid_ready", req_ready, 0);
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
    n = 0;
    last_busy = uart_tx_busy;
    do begin
      last_busy = uart_tx_busy;
      cycle();
      n++;
    end while (s_ready == '0 && n < 30);
    chk("mid_accept", s_ready, 4'b0010);
    chk("mid_accept_after_fall", last_busy, 0);
    chk("mid_no_early_accept", n > 1, 1);
    drain(100);
    busy_min = 1; busy_max = 5;

    // Randomized traffic, no reset between rounds.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        n = $urandom_range(6, 0);
        for (int j = 0; j < n; j++) begin
          rq[i].push_back({(j == n - 1) ? 1'b1 : 1'($urandom_range(1, 0)), 8'($urandom)});
        end
      end
      drive();
      drain(3000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
